// File: rtl/plataform_scroller.sv
// Vertical platform position generator: NUM_PLAT equally spaced platforms that
// move down one row per divided tick, continuously or as a counted scroll request.
module plataform_scroller #(
  parameter int NUM_PLAT = 4,
  parameter int HEIGHT   = 30,
  parameter int SPACING  = 120,
  parameter int SCREEN_H = 480,
  parameter int TICK_DIV = 840000,
  parameter int CNT_W    = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scroll_en,
  input  logic                  req_valid,
  input  logic [9:0]            req_amount,
  output logic                  req_ready,
  output logic                  busy,
  output logic                  done,
  input  logic [9:0]            pix_y,
  output logic [10*NUM_PLAT-1:0] plat_start,
  output logic                  plat_hit,
  output logic [3:0]            plat_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [9:0]       SCREEN_LAST = 10'(SCREEN_H - 1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           div_q, div_d;
  logic [9:0]                 rem_q, rem_d;
  logic [NUM_PLAT-1:0][9:0]   start_q, start_d;
  logic                       req_ready_q, req_ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       run, tick, step;
  logic [NUM_PLAT-1:0]        hit_vec;

  always_comb begin
    run     = (state_q == SCROLL) || ((state_q == IDLE) && scroll_en);
    tick    = run && (div_q == DIV_LAST);
    div_d   = (!run || tick) ? '0 : div_q + CNT_W'(1);
    state_d = state_q;
    rem_d   = rem_q;
    step    = 1'b0;

    case (state_q)
      IDLE: begin
        // An accepted request restarts the divider and suppresses any coincident continuous step.
        if (req_valid) begin
          div_d = '0;
          if (req_amount != 10'd0) begin
            rem_d   = req_amount;
            state_d = SCROLL;
          end else begin
            state_d = DONE;
          end
        end else if (tick) begin
          step = 1'b1;
        end
      end
      SCROLL: begin
        if (tick) begin
          step  = 1'b1;
          rem_d = rem_q - 10'd1;
          if (rem_q == 10'd1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_PLAT; i++) begin
      start_d[i] = start_q[i];
      if (step) start_d[i] = (start_q[i] == SCREEN_LAST) ? '0 : start_q[i] + 10'd1;
    end

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      rem_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_PLAT; i++) start_q[i] <= 10'(i * SPACING);
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_q     <= start_d;
    end
  end

  // Bands are compared in 11 bits so a platform near the bottom never wraps to row 0.
  always_comb begin
    plat_idx = '0;
    for (int unsigned i = 0; i < NUM_PLAT; i++) begin
      hit_vec[i] = ({1'b0, pix_y} >= {1'b0, start_q[i]}) &&
                   ({1'b0, pix_y} <  ({1'b0, start_q[i]} + 11'(HEIGHT)));
    end
    for (int unsigned j = 0; j < NUM_PLAT; j++) begin
      if (hit_vec[NUM_PLAT-1-j]) plat_idx = 4'(NUM_PLAT - 1 - j);
    end
  end

  assign plat_hit   = |hit_vec;
  assign plat_start = start_q;
  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_plataform_scroller.sv
// Directed bench for plataform_scroller with a fast divider (TICK_DIV=4).
module tb_plataform_scroller;

  logic        clk = 1'b0;
  logic        rst;
  logic        scroll_en;
  logic        req_valid;
  logic [9:0]  req_amount;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic [9:0]  pix_y;
  logic [39:0] plat_start;
  logic        plat_hit;
  logic [3:0]  plat_idx;

  int errors = 0;
  int checks = 0;

  plataform_scroller #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .scroll_en  (scroll_en),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .busy       (busy),
    .done       (done),
    .pix_y      (pix_y),
    .plat_start (plat_start),
    .plat_hit   (plat_hit),
    .plat_idx   (plat_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [9:0] sp(input int i);
    return plat_start[10*i +: 10];
  endfunction

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step_clk(2);
    rst = 1'b0;
    step_clk(1);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (plat_start !== {10'd360, 10'd240, 10'd120, 10'd0}) begin errors++; $display("FAIL reset_start: got %h want %h", plat_start, {10'd360, 10'd240, 10'd120, 10'd0}); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    pix_y = 10'd125; #1;
    checks++; if (plat_hit !== 1'b1) begin errors++; $display("FAIL hit_125: got %b want 1", plat_hit); end
    checks++; if (plat_idx !== 4'd1) begin errors++; $display("FAIL idx_125: got %0d want 1", plat_idx); end
    pix_y = 10'd150; #1;
    checks++; if (plat_hit !== 1'b0) begin errors++; $display("FAIL hit_150: got %b want 0", plat_hit); end
    checks++; if (plat_idx !== 4'd0) begin errors++; $display("FAIL idx_150: got %0d want 0", plat_idx); end
  endtask

  task automatic test_request();
    req_valid = 1'b1; req_amount = 10'd3;
    step_clk(1);
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL req_busy_e1: got %b want 1", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL req_ready_e1: got %b want 0", req_ready); end
    for (int k = 1; k <= 3; k++) begin
      step_clk(4);
      checks++; if (sp(0) !== 10'(k)) begin errors++; $display("FAIL req_step%0d: got %0d want %0d", k, sp(0), k); end
      checks++; if (done !== (k == 3)) begin errors++; $display("FAIL req_done%0d: got %b want %b", k, done, (k == 3)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL req_busy%0d: got %b want 1", k, busy); end
    end
    step_clk(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL req_done_after: got %b want 0", done); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_after: got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_busy_after: got %b want 0", busy); end
    checks++; if (sp(3) !== 10'd363) begin errors++; $display("FAIL req_p3: got %0d want 363", sp(3)); end
  endtask

  task automatic test_wrap();
    apply_reset();
    scroll_en = 1'b1;
    step_clk(400);
    checks++; if (sp(3) !== 10'd460) begin errors++; $display("FAIL wrap_p3_100: got %0d want 460", sp(3)); end
    checks++; if (sp(0) !== 10'd100) begin errors++; $display("FAIL wrap_p0_100: got %0d want 100", sp(0)); end
    pix_y = 10'd470; #1;
    checks++; if (plat_hit !== 1'b1) begin errors++; $display("FAIL wrap_hit_470: got %b want 1", plat_hit); end
    checks++; if (plat_idx !== 4'd3) begin errors++; $display("FAIL wrap_idx_470: got %0d want 3", plat_idx); end
    pix_y = 10'd5; #1;
    checks++; if (plat_hit !== 1'b0) begin errors++; $display("FAIL wrap_nohit_5: got %b want 0", plat_hit); end
    step_clk(76);
    checks++; if (sp(3) !== 10'd479) begin errors++; $display("FAIL wrap_p3_119: got %0d want 479", sp(3)); end
    step_clk(4);
    checks++; if (sp(3) !== 10'd0) begin errors++; $display("FAIL wrap_p3_120: got %0d want 0", sp(3)); end
    checks++; if (sp(0) !== 10'd120) begin errors++; $display("FAIL wrap_p0_120: got %0d want 120", sp(0)); end
    // Partial divider count is discarded when scroll_en drops.
    step_clk(3);
    scroll_en = 1'b0;
    step_clk(1);
    scroll_en = 1'b1;
    step_clk(3);
    checks++; if (sp(0) !== 10'd120) begin errors++; $display("FAIL partial_hold: got %0d want 120", sp(0)); end
    step_clk(1);
    checks++; if (sp(0) !== 10'd121) begin errors++; $display("FAIL partial_step: got %0d want 121", sp(0)); end
    scroll_en = 1'b0;
  endtask

  task automatic test_arbitration();
    apply_reset();
    scroll_en = 1'b1;
    step_clk(3);
    req_valid = 1'b1; req_amount = 10'd2;
    step_clk(1);
    req_valid = 1'b0; scroll_en = 1'b0;
    checks++; if (sp(0) !== 10'd0) begin errors++; $display("FAIL arb_no_step: got %0d want 0", sp(0)); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arb_busy: got %b want 1", busy); end
    step_clk(1);
    req_valid = 1'b1; req_amount = 10'd7;
    step_clk(1);
    req_valid = 1'b0;
    step_clk(2);
    checks++; if (sp(0) !== 10'd1) begin errors++; $display("FAIL arb_step1: got %0d want 1", sp(0)); end
    req_valid = 1'b1;
    step_clk(1);
    req_valid = 1'b0;
    step_clk(3);
    checks++; if (sp(0) !== 10'd2) begin errors++; $display("FAIL arb_step2: got %0d want 2", sp(0)); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL arb_done: got %b want 1", done); end
    req_valid = 1'b1;
    step_clk(1);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL arb_ready: got %b want 1", req_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arb_done_clear: got %b want 0", done); end
    step_clk(12);
    checks++; if (sp(0) !== 10'd2) begin errors++; $display("FAIL arb_total: got %0d want 2", sp(0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_amount();
    req_valid = 1'b1; req_amount = 10'd0;
    step_clk(1);
    req_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b want 1", busy); end
    checks++; if (plat_start !== {10'd362, 10'd242, 10'd122, 10'd2}) begin errors++; $display("FAIL zero_start: got %h want %h", plat_start, {10'd362, 10'd242, 10'd122, 10'd2}); end
    step_clk(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_clear: got %b want 0", done); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_abort();
    apply_reset();
    req_valid = 1'b1; req_amount = 10'd5;
    step_clk(1);
    req_valid = 1'b0;
    step_clk(8);
    checks++; if (sp(0) !== 10'd2) begin errors++; $display("FAIL abort_pre: got %0d want 2", sp(0)); end
    #2 rst = 1'b1;
    #1;
    checks++; if (plat_start !== {10'd360, 10'd240, 10'd120, 10'd0}) begin errors++; $display("FAIL abort_start: got %h want %h", plat_start, {10'd360, 10'd240, 10'd120, 10'd0}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    step_clk(2);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done_rst: got %b want 0", done); end
    rst = 1'b0;
    step_clk(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done_post: got %b want 0", done); end
    req_valid = 1'b1; req_amount = 10'd1;
    step_clk(1);
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_new_busy: got %b want 1", busy); end
    step_clk(4);
    checks++; if (sp(0) !== 10'd1) begin errors++; $display("FAIL abort_new_step: got %0d want 1", sp(0)); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_new_done: got %b want 1", done); end
    step_clk(1);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_new_ready: got %b want 1", req_ready); end
  endtask

  initial begin
    rst = 1'b1; scroll_en = 1'b0; req_valid = 1'b0; req_amount = '0; pix_y = '0;
    test_reset();
    test_request();
    test_wrap();
    test_arbitration();
    test_zero_amount();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plataform_scroller.md
# plataform_scroller

Parametrised platform-position generator for the vertical-scrolling playfield. Tracks `NUM_PLAT` equally spaced platforms, each `HEIGHT` rows tall. Platforms move down one row per divided tick, either continuously or as a requested scroll of N rows with a ready/busy/done handshake. Sits between game logic (scroll requests) and the VGA pixel pipeline, which queries platform hits per scanline row.

## Interface
Parameters:
- `NUM_PLAT`, 4, number of platforms, range 1..16.
- `HEIGHT`, 30, platform thickness in rows.
- `SPACING`, 120, reset distance between consecutive platform tops. Constraint: (NUM_PLAT-1)*SPACING < SCREEN_H.
- `SCREEN_H`, 480, vertical wrap modulus in rows, at most 1023.
- `TICK_DIV`, 840000, clk cycles per one-row step, at least 2.
- `CNT_W`, 20, divider width. Constraint: 2^CNT_W > TICK_DIV.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `scroll_en`  in  1  continuous-scroll enable; honoured only in IDLE.
- `req_valid`  in  1  scroll request strobe.
- `req_amount`  in  10  rows to scroll for the request.
- `req_ready`  out  1  high in IDLE.
- `busy`  out  1  high in SCROLL or DONE.
- `done`  out  1  one-cycle pulse when a request completes.
- `pix_y`  in  10  row being queried by the video pipeline.
- `plat_start`  out  10*NUM_PLAT  packed platform top rows; platform i occupies bits [10i+9:10i].
- `plat_hit`  out  1  combinational: `pix_y` lies inside some platform.
- `plat_idx`  out  4  combinational: lowest hit index; 0 when no platform is hit.

## Operation
- Reset values:
  - start[i] = i*SPACING.
  - Divider = 0; state = IDLE; remaining = 0.
  - `done` = 0, `busy` = 0, `req_ready` = 1.
- Step (applied to all platforms in the same edge):
  - start[i] <= start[i]+1.
  - If start[i]+1 == SCREEN_H, then start[i] <= 0.
  - Sums are 10-bit; start never reaches SCREEN_H.
- Divider:
  - Runs while state == SCROLL, or while state == IDLE and scroll_en == 1. Otherwise it is held at 0.
  - Counts 0..TICK_DIV-1. A tick occurs in the cycle it equals TICK_DIV-1, and the divider returns to 0 on that edge.
- FSM:
  - IDLE:
    - On req_valid with req_amount != 0: latch remaining = req_amount, clear divider, go to SCROLL.
    - On req_valid with req_amount == 0: go directly to DONE.
    - Otherwise, if scroll_en is set: step on each tick.
  - SCROLL: on each tick, step and decrement remaining. When the step brings remaining to 0, go to DONE on that edge.
  - DONE: `done` = 1 for exactly this one cycle, then go to IDLE.
- Request arbitration:
  - A request in IDLE wins over scroll_en in the same cycle. No continuous step occurs on that edge, even if a tick coincides.
  - req_valid outside IDLE is ignored and is not queued.
- Hit test:
  - Platform i covers rows start[i] .. start[i]+HEIGHT-1 computed in 11 bits. Rows ≥ SCREEN_H are off-screen; the band does not wrap to the top.
  - plat_hit is the OR over all platforms.
  - plat_idx is a priority encode, lowest index first.

## Timing
- Registered outputs: `plat_start`, `busy`, `done`, `req_ready`. State and positions change only on clk rising edges, or asynchronously on rst.
- `plat_hit` and `plat_idx` are purely combinational from `pix_y` and the current `plat_start`, with zero latency.
- Request latency:
  - Accepted at edge E.
  - First step at edge E+TICK_DIV.
  - Last step at edge E+req_amount*TICK_DIV.
  - `done` high during the cycle after the last step.
  - Back in IDLE (req_ready=1) one cycle later.
- Zero-amount request: `done` high the cycle after acceptance, with no position change.
- Continuous mode: one step every TICK_DIV cycles while scroll_en stays high. Deasserting scroll_en clears the divider, so the partial count is lost.
- rst mid-SCROLL: all registers return to reset values immediately. No `done` is emitted for the aborted request.

## Test plan
- Reset check (TICK_DIV=4, defaults): assert rst, then release it.
  - Expect plat_start = {360,240,120,0}, req_ready=1, busy=0, done=0.
  - With pix_y=125: plat_hit=1, plat_idx=1.
  - With pix_y=150: plat_hit=0.
- Request of 3 accepted at edge E:
  - Platform 0 reads 1, 2, 3 after edges E+4, E+8, E+12.
  - `done` high exactly one cycle after E+12; busy high from E+1 through the done cycle.
- Wrap: scroll_en=1 for 120 ticks. Platform 3 goes 479→0 on the 120th step; platform 0 then reads 120. A query at pix_y=470 with start=460 hits, and no hit appears in rows 0..9 from that band.
- Arbitration: req_valid asserted in the same cycle as a continuous tick yields no step on that edge. req_valid pulses during SCROLL are ignored, so the total step count equals the first amount only.
- Zero amount: req_amount=0 gives done=1 on the next cycle, and plat_start is unchanged.
- Abort: rst asserted at step 2 of a 5-row request restores reset positions asynchronously. No done pulse occurs, and a fresh request is accepted normally.
